// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexes four hex digits plus decimal points onto a
// common-anode 4-digit seven-segment display. A slot counter divides the
// system clock into per-digit slots, each starting with a dark (blank) window
// so segments are swapped while every anode is off. Digit values are captured
// into shadow registers once per frame so a display frame never tears.
// Optional build macro: SSD_LZ_BLANK_EN enables leading-zero suppression.
module ssd_scan_mux #(
    parameter int c_REFRESH_DIV = 100000,
    parameter int c_BLANK_CYC   = 1000
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_EN,
    input  logic [3:0] i_Digit_1_val,
    input  logic [3:0] i_Digit_2_val,
    input  logic [3:0] i_Digit_3_val,
    input  logic [3:0] i_Digit_4_val,
    input  logic [3:0] i_DP,
    output logic [3:0] o_Anode,
    output logic [6:0] o_Seg,
    output logic       o_DP,
    output logic       o_Frame
);

    localparam int c_CNT_W = (c_REFRESH_DIV > 1) ? $clog2(c_REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(c_BLANK_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = c_CNT_W'(0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Active-low hex font, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Select 0 is the leftmost digit; anodes are active-low.
    function automatic logic [3:0] f_sel_to_anode(input logic [1:0] sel);
        logic [3:0] an;
        case (sel)
            2'd0:    an = 4'b0111;
            2'd1:    an = 4'b1011;
            2'd2:    an = 4'b1101;
            2'd3:    an = 4'b1110;
            default: an = 4'b1111;
        endcase
        return an;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [c_CNT_W-1:0]   cnt_r;
    logic [c_CNT_W-1:0]   cnt_s;
    logic [1:0]           sel_r;
    logic [1:0]           sel_s;
    logic                 capture_s;
    logic [3:0][3:0]      shadow_dig_r;   // index 0 = digit 1 (leftmost)
    logic [3:0]           shadow_dp_r;    // bit 3 = digit 1
    logic [1:0]           dp_idx_s;
    logic [6:0]           seg_sel_s;
    logic [3:0]           anode_s;
    logic [6:0]           seg_s;
    logic                 dp_s;
    logic [3:0]           anode_r;
    logic [6:0]           seg_r;
    logic                 dp_r;
    logic                 frame_r;

    assign dp_idx_s = 2'd3 - sel_r;

`ifdef SSD_LZ_BLANK_EN
    // A digit is suppressed while it and every digit to its left are zero
    // with no lit decimal point; the rightmost digit is never suppressed.
    logic lz_1_s;
    logic lz_2_s;
    logic lz_3_s;
    logic lz_sel_s;

    assign lz_1_s = (shadow_dig_r[0] == 4'h0) && !shadow_dp_r[3];
    assign lz_2_s = lz_1_s && (shadow_dig_r[1] == 4'h0) && !shadow_dp_r[2];
    assign lz_3_s = lz_2_s && (shadow_dig_r[2] == 4'h0) && !shadow_dp_r[1];

    // Pick the suppression flag for the digit currently selected.
    always_comb begin
        lz_sel_s = 1'b0;
        case (sel_r)
            2'd0:    lz_sel_s = lz_1_s;
            2'd1:    lz_sel_s = lz_2_s;
            2'd2:    lz_sel_s = lz_3_s;
            default: lz_sel_s = 1'b0;
        endcase
    end

    assign seg_sel_s = lz_sel_s ? 7'h7F : f_hex_to_seg(shadow_dig_r[sel_r]);
`else
    assign seg_sel_s = f_hex_to_seg(shadow_dig_r[sel_r]);
`endif

    // Next-state logic: slot counter, digit rotation and frame capture strobe.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sel_s     = sel_r;
        capture_s = 1'b0;
        if (!i_EN) begin
            state_s = ST_IDLE;
            cnt_s   = c_CNT_ZERO;
            sel_s   = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s   = ST_BLANK;
                    cnt_s     = c_CNT_ZERO;
                    sel_s     = 2'd0;
                    capture_s = 1'b1;
                end
                ST_BLANK, ST_DRIVE: begin
                    if (cnt_r == c_CNT_LAST) begin
                        state_s   = ST_BLANK;
                        cnt_s     = c_CNT_ZERO;
                        sel_s     = sel_r + 2'd1;
                        capture_s = (sel_r == 2'd3);
                    end else begin
                        cnt_s = cnt_r + c_CNT_ONE;
                        if (cnt_r == c_BLANK_END) begin
                            state_s = ST_DRIVE;
                        end else begin
                            state_s = state_r;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = c_CNT_ZERO;
                    sel_s   = 2'd0;
                end
            endcase
        end
    end

    // Output decode from the current state; disable darkens on the next edge.
    always_comb begin
        anode_s = 4'b1111;
        seg_s   = 7'h7F;
        dp_s    = 1'b1;
        if (i_EN) begin
            case (state_r)
                ST_BLANK: begin
                    seg_s = seg_sel_s;
                end
                ST_DRIVE: begin
                    anode_s = f_sel_to_anode(sel_r);
                    seg_s   = seg_sel_s;
                    dp_s    = ~shadow_dp_r[dp_idx_s];
                end
                default: begin
                    anode_s = 4'b1111;
                    seg_s   = 7'h7F;
                    dp_s    = 1'b1;
                end
            endcase
        end else begin
            anode_s = 4'b1111;
            seg_s   = 7'h7F;
            dp_s    = 1'b1;
        end
    end

    // Scan state registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= c_CNT_ZERO;
            sel_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
        end
    end

    // Shadow capture at frame start only, so a frame is never torn.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            shadow_dig_r <= 16'h0000;
            shadow_dp_r  <= 4'h0;
        end else if (capture_s) begin
            shadow_dig_r <= {i_Digit_4_val, i_Digit_3_val, i_Digit_2_val, i_Digit_1_val};
            shadow_dp_r  <= i_DP;
        end else begin
            shadow_dig_r <= shadow_dig_r;
            shadow_dp_r  <= shadow_dp_r;
        end
    end

    // Registered display outputs; anode and segments update on the same edge.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            anode_r <= 4'b1111;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            anode_r <= anode_s;
            seg_r   <= seg_s;
            dp_r    <= dp_s;
            frame_r <= capture_s;
        end
    end

    assign o_Anode = anode_r;
    assign o_Seg   = seg_r;
    assign o_DP    = dp_r;
    assign o_Frame = frame_r;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed testbench for ssd_scan_mux with an 8-cycle slot and 2 blank cycles.
// Outputs are sampled on the falling clock edge; n counts falling edges after
// the one where o_Frame is seen high (n=32 is the next frame pulse).
module tb_ssd_scan_mux;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] d1, d2, d3, d4, dpv;
    logic [3:0] o_Anode;
    logic [6:0] o_Seg;
    logic       o_DP;
    logic       o_Frame;

    int checks = 0;
    int errors = 0;

    logic [3:0] oa  [1:32];
    logic [6:0] os  [1:32];
    logic       od  [1:32];
    logic       ofr [1:32];

    ssd_scan_mux #(.c_REFRESH_DIV(8), .c_BLANK_CYC(2)) dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .i_EN          (en),
        .i_Digit_1_val (d1),
        .i_Digit_2_val (d2),
        .i_Digit_3_val (d3),
        .i_Digit_4_val (d4),
        .i_DP          (dpv),
        .o_Anode       (o_Anode),
        .o_Seg         (o_Seg),
        .o_DP          (o_DP),
        .o_Frame       (o_Frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one 32-cycle frame; optionally change inputs after sample chg_n.
    task automatic capture_frame(input int chg_n, input logic [3:0] n1, n2, n3, n4, ndp);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            oa[n] = o_Anode; os[n] = o_Seg; od[n] = o_DP; ofr[n] = o_Frame;
            if (n == chg_n) begin
                d1 = n1; d2 = n2; d3 = n3; d4 = n4; dpv = ndp;
            end
        end
    endtask

    // Bounded wait for the next frame pulse.
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (o_Frame === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_frame: o_Frame stayed 0 for 80 cycles, required a pulse");
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks += 4;
        if (o_Anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got %b exp 1111", o_Anode); end
        if (o_Seg !== 7'h7F)     begin errors++; $display("FAIL reset_seg got %h exp 7f", o_Seg); end
        if (o_DP !== 1'b1)       begin errors++; $display("FAIL reset_dp got %b exp 1", o_DP); end
        if (o_Frame !== 1'b0)    begin errors++; $display("FAIL reset_frame got %b exp 0", o_Frame); end
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4; dpv = 4'b0000;
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        checks += 2;
        if (o_Frame !== 1'b1)    begin errors++; $display("FAIL start_frame got %b exp 1", o_Frame); end
        if (o_Anode !== 4'b1111) begin errors++; $display("FAIL start_anode got %b exp 1111", o_Anode); end
    endtask

    task automatic test_scan();
        logic [6:0] es [4];
        logic [3:0] ea, sh;
        logic       ed, ef;
        int s, p;
        es = '{7'h79, 7'h24, 7'h30, 7'h19};
        capture_frame(0, d1, d2, d3, d4, dpv);
        for (int n = 1; n <= 32; n++) begin
            s = (n - 1) / 8; p = (n - 1) % 8;
            sh = 4'b1000 >> s;
            ea = (p < 2) ? 4'b1111 : ~sh;
            ed = 1'b1;
            ef = (n == 32);
            checks += 4;
            if (oa[n] !== ea)     begin errors++; $display("FAIL scan_anode n=%0d got %b exp %b", n, oa[n], ea); end
            if (os[n] !== es[s])  begin errors++; $display("FAIL scan_seg n=%0d got %h exp %h", n, os[n], es[s]); end
            if (od[n] !== ed)     begin errors++; $display("FAIL scan_dp n=%0d got %b exp %b", n, od[n], ed); end
            if (ofr[n] !== ef)    begin errors++; $display("FAIL scan_frame n=%0d got %b exp %b", n, ofr[n], ef); end
        end
    endtask

    task automatic test_reset_mid_drive();
        logic [3:0] ea;
        repeat (3) @(negedge clk);
        checks += 2;
        if (o_Anode !== 4'b0111) begin errors++; $display("FAIL pre_rst_anode got %b exp 0111", o_Anode); end
        if (o_Seg !== 7'h79)     begin errors++; $display("FAIL pre_rst_seg got %h exp 79", o_Seg); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (o_Anode !== 4'b1111) begin errors++; $display("FAIL async_rst_anode got %b exp 1111", o_Anode); end
        if (o_Seg !== 7'h7F)     begin errors++; $display("FAIL async_rst_seg got %h exp 7f", o_Seg); end
        if (o_DP !== 1'b1)       begin errors++; $display("FAIL async_rst_dp got %b exp 1", o_DP); end
        if (o_Frame !== 1'b0)    begin errors++; $display("FAIL async_rst_frame got %b exp 0", o_Frame); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_Frame !== 1'b1) begin errors++; $display("FAIL rst_release_frame got %b exp 1", o_Frame); end
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            ea = (n < 3) ? 4'b1111 : 4'b0111;
            checks++;
            if (o_Anode !== ea) begin errors++; $display("FAIL rst_release_anode n=%0d got %b exp %b", n, o_Anode, ea); end
        end
    endtask

    task automatic test_no_tearing();
        logic [6:0] es [8];
        logic [3:0] ea, sh;
        logic       ef;
        int s, p;
        es = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
        wait_frame();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) capture_frame(10, 4'hA, 4'hB, 4'hC, 4'hD, 4'b0000);
            else        capture_frame(0, d1, d2, d3, d4, dpv);
            for (int n = 1; n <= 32; n++) begin
                s = (n - 1) / 8; p = (n - 1) % 8;
                sh = 4'b1000 >> s;
                ea = (p < 2) ? 4'b1111 : ~sh;
                ef = (n == 32);
                checks += 3;
                if (oa[n] !== ea)         begin errors++; $display("FAIL tear_anode f=%0d n=%0d got %b exp %b", f, n, oa[n], ea); end
                if (os[n] !== es[4*f+s])  begin errors++; $display("FAIL tear_seg f=%0d n=%0d got %h exp %h", f, n, os[n], es[4*f+s]); end
                if (ofr[n] !== ef)        begin errors++; $display("FAIL tear_frame f=%0d n=%0d got %b exp %b", f, n, ofr[n], ef); end
            end
        end
    endtask

    task automatic test_dp_enable();
        logic [6:0] es [8];
        logic [3:0] ev [2];
        logic [3:0] ea, sh;
        logic       ed;
        int s, p;
`ifdef SSD_LZ_BLANK_EN
        es = '{7'h7F, 7'h40, 7'h40, 7'h78, 7'h12, 7'h02, 7'h78, 7'h00};
`else
        es = '{7'h40, 7'h40, 7'h40, 7'h78, 7'h12, 7'h02, 7'h78, 7'h00};
`endif
        ev = '{4'b0100, 4'b0001};
        d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; d4 = 4'h7; dpv = 4'b0100;
        wait_frame();
        for (int f = 0; f < 2; f++) begin
            capture_frame(0, d1, d2, d3, d4, dpv);
            for (int n = 1; n <= 32; n++) begin
                s = (n - 1) / 8; p = (n - 1) % 8;
                sh = 4'b1000 >> s;
                ea = (p < 2) ? 4'b1111 : ~sh;
                ed = (p < 2) ? 1'b1 : ~ev[f][3-s];
                checks += 3;
                if (oa[n] !== ea)        begin errors++; $display("FAIL dp_anode f=%0d n=%0d got %b exp %b", f, n, oa[n], ea); end
                if (os[n] !== es[4*f+s]) begin errors++; $display("FAIL dp_seg f=%0d n=%0d got %h exp %h", f, n, os[n], es[4*f+s]); end
                if (od[n] !== ed)        begin errors++; $display("FAIL dp_dp f=%0d n=%0d got %b exp %b", f, n, od[n], ed); end
            end
            if (f == 0) begin
                repeat (12) @(negedge clk);
                checks += 2;
                if (o_Anode !== 4'b1011) begin errors++; $display("FAIL pre_dis_anode got %b exp 1011", o_Anode); end
                if (o_DP !== 1'b0)       begin errors++; $display("FAIL pre_dis_dp got %b exp 0", o_DP); end
                en = 1'b0;
                @(negedge clk);
                checks += 4;
                if (o_Anode !== 4'b1111) begin errors++; $display("FAIL dis_anode got %b exp 1111", o_Anode); end
                if (o_Seg !== 7'h7F)     begin errors++; $display("FAIL dis_seg got %h exp 7f", o_Seg); end
                if (o_DP !== 1'b1)       begin errors++; $display("FAIL dis_dp got %b exp 1", o_DP); end
                if (o_Frame !== 1'b0)    begin errors++; $display("FAIL dis_frame got %b exp 0", o_Frame); end
                repeat (3) @(negedge clk);
                checks += 2;
                if (o_Anode !== 4'b1111) begin errors++; $display("FAIL dis_hold_anode got %b exp 1111", o_Anode); end
                if (o_Frame !== 1'b0)    begin errors++; $display("FAIL dis_hold_frame got %b exp 0", o_Frame); end
                d1 = 4'h5; d2 = 4'h6; d3 = 4'h7; d4 = 4'h8; dpv = 4'b0001;
                en = 1'b1;
                @(negedge clk);
                checks += 2;
                if (o_Frame !== 1'b1)    begin errors++; $display("FAIL reen_frame got %b exp 1", o_Frame); end
                if (o_Anode !== 4'b1111) begin errors++; $display("FAIL reen_anode got %b exp 1111", o_Anode); end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es [8];
        int s;
`ifdef SSD_LZ_BLANK_EN
        es = '{7'h7F, 7'h7F, 7'h12, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        es = '{7'h40, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
        for (int f = 0; f < 2; f++) begin
            d1 = 4'h0; d2 = 4'h0; d3 = (f == 0) ? 4'h5 : 4'h0; d4 = 4'h0; dpv = 4'b0000;
            wait_frame();
            capture_frame(0, d1, d2, d3, d4, dpv);
            for (int n = 1; n <= 32; n++) begin
                s = (n - 1) / 8;
                checks++;
                if (os[n] !== es[4*f+s]) begin errors++; $display("FAIL lz_seg f=%0d n=%0d got %h exp %h", f, n, os[n], es[4*f+s]); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0;
        d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; d4 = 4'h0; dpv = 4'h0;
        #3 rst = 1'b1;
        test_reset();
        test_scan();
        test_reset_mid_drive();
        test_no_tearing();
        test_dp_enable();
        test_lz();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Downstream consumer of the stopwatch digit counter: takes four 4-bit digit values plus decimal points and time-multiplexes them onto a common-anode 4-digit seven-segment display (Basys-class board).
- Holds a refresh divider, a digit-select rotator with anti-ghosting blank time, frame-synchronous input capture, and a hex-to-segment decoder.
- Runs on the fast system clock, not the stopwatch subclock.

Parameters:
c_REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 4.
c_BLANK_CYC, 1000, cycles at start of each slot with all anodes off; must satisfy 1 <= c_BLANK_CYC < c_REFRESH_DIV.

Ports:
i_CLK  input  1  system clock.
i_RST  input  1  reset, asynchronous, active-high.
i_EN  input  1  display enable; low = display dark.
i_Digit_1_val  input  4  most significant (leftmost) digit, 0-F.
i_Digit_2_val  input  4  second digit.
i_Digit_3_val  input  4  third digit.
i_Digit_4_val  input  4  least significant (rightmost) digit.
i_DP  input  4  decimal points; bit 3 = digit 1 ... bit 0 = digit 4; 1 = lit.
o_Anode  output  4  active-low anodes; bit 3 = digit 1 ... bit 0 = digit 4.
o_Seg  output  7  active-low segments {g,f,e,d,c,b,a}.
o_DP  output  1  active-low decimal point.
o_Frame  output  1  one-cycle pulse when a new frame's inputs are captured.

Behaviour:
- Reset (async, active-high): o_Anode=4'b1111, o_Seg=7'h7F, o_DP=1, o_Frame=0, slot counter=0, select=0, shadow digits/DP=0, state IDLE. Mid-operation reset darkens outputs immediately, with no wait for a clock edge.
- States:
  - IDLE: anodes off; counter and select held at 0.
  - BLANK: anodes off; segments preloaded for the selected digit.
  - DRIVE: one anode low for the selected digit.
- IDLE -> BLANK on first clock with i_EN=1. That edge captures all four digits and i_DP into shadow registers, and o_Frame pulses.
- Slot counter runs 0..c_REFRESH_DIV-1.
  - BLANK for counts 0..c_BLANK_CYC-1; DRIVE for the remainder.
  - At terminal count, counter wraps to 0, select advances 0->1->2->3->0, and state returns to BLANK.
- Select order: 0 = digit 1 (o_Anode=4'b0111), 1 = digit 2 (4'b1011), 2 = digit 3 (4'b1101), 3 = digit 4 (4'b1110).
- Frame capture: shadow registers load only when select wraps 3->0 (and on IDLE exit), with a one-cycle o_Frame pulse. Input changes mid-frame are never shown until the next frame (no tearing). Frame length = 4*c_REFRESH_DIV cycles.
- Any cycle with i_EN=0: next edge forces IDLE and all-off outputs. The shadow registers retain their values.
- Decoder: standard hex font, 0-F.
  - Active-low codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- o_DP = ~shadow_DP[selected] in DRIVE; 1 otherwise.
- Latency: outputs are registered. o_Anode/o_Seg/o_DP reflect the state/counter value of the previous cycle (1-cycle latency). Anode and segment changes always land on the same edge.
- Segments change only while anodes are off. BLANK guarantees at least c_BLANK_CYC dark cycles between digits.

Optional Feature:
- Macro: SSD_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit k (k=1..3) is blanked (o_Seg=7'h7F, anode still scanned) when it and all more-significant shadow digits equal 0. Digit 4 is always shown. A lit DP on a suppressed digit disables suppression for that digit and all digits to its right.
- Undefined: all four digits are always decoded; no suppression logic is synthesized.

Test Plan:
All scenarios use c_REFRESH_DIV=8, c_BLANK_CYC=2.
- Reset mid-DRIVE: assert i_RST asynchronously between edges -> o_Anode=1111, o_Seg=7F, o_DP=1 immediately. Release with i_EN=1 -> o_Frame pulse, then digit 1 lit from cycle 3 of its slot.
- Digits 1,2,3,4 with i_DP=0000: per 8-cycle slot, 2 dark cycles then 6 cycles of the correct anode. Segment codes are 79, 24, 30, 19 in order. Frame period is 32 cycles.
- Change inputs to A,b,C,d while select=1: digits 2-4 of the current frame still show 2,3,4. The next frame shows 08, 03, 46, 21, and o_Frame pulses exactly at the 3->0 wrap.
- i_DP=0100 with digits 0,0,0,7: o_DP=0 only during digit 2 DRIVE cycles. i_EN dropped mid-slot -> all off next edge; re-enable restarts at digit 1 with a fresh capture.
- SSD_LZ_BLANK_EN defined, digits 0,0,5,0, i_DP=0000: digits 1-2 show 7F, digit 3 shows 12, digit 4 shows 40. Digits 0,0,0,0 show 7F, 7F, 7F, 40. Undefined: 40, 40, 12, 40.
